btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
Upstream input stage for the counter FSM. It turns the raw, asynchronous start and pause push-buttons into clean, clock-aligned control signals, and generates the periodic count pulse.
- start is a single-cycle strobe on each debounced press.
- pause is a debounced level.
- pulse is a one-cycle tick every PRESCALE clocks while enabled.
- Outputs connect directly to the FSM's start, pause and pulse inputs.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a level change; legal range 1..255.
PRESCALE, 100, pulse period in clock cycles; legal range 1..65535.

Ports:
clk  input  1  system clock, all flops on rising edge
rst  input  1  reset, synchronous, active-low; sampled on rising clk edge
start_btn  input  1  raw start button, asynchronous, may bounce
pause_btn  input  1  raw pause button, asynchronous, may bounce
tick_en  input  1  synchronous enable for the pulse prescaler
start  output  1  one-cycle strobe on each debounced start_btn press
pause  output  1  debounced level of pause_btn
pulse  output  1  one-cycle tick every PRESCALE cycles while tick_en=1

Behaviour:
- Reset (rst=0 at a clk edge): all synchronizer flops, debounce counters and prescaler counter clear to 0. Both debounce FSMs go to S_LOW. Outputs start=0, pause=0, pulse=0 from the following cycle. Reset mid-debounce or mid-period aborts the operation with no output.
- Synchronizer: each button passes through 2 flops (s1, s2). The FSMs see only s2.
- Debounce FSM, one per button; states S_LOW, W_HIGH, S_HIGH, W_LOW. Counter width is 8 bits.
  - S_LOW: if s2=1, go to W_HIGH with cnt=1.
  - W_HIGH: if s2=0, return to S_LOW. Else if cnt==DEBOUNCE_CYCLES, go to S_HIGH. Else cnt++.
  - S_HIGH: if s2=0, go to W_LOW with cnt=1.
  - W_LOW: mirror of W_HIGH; s2=1 returns to S_HIGH, completion goes to S_LOW.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no output change.
- Latency: raw level first sampled into s1 at edge E0 gives the debounced change at edge E0+DEBOUNCE_CYCLES+2.
- start: registered. Set to 1 on the edge where the start FSM moves W_HIGH to S_HIGH, and 0 on all other edges. Exactly one strobe per accepted press, regardless of hold time. Release produces no strobe.
- pause: registered. 1 while the pause FSM is in S_HIGH or W_LOW, updated on the same edge as the state change.
- Button held through reset: after reset release it is debounced as a fresh press and produces a start strobe or pause=1. This is the required behaviour.
- Simultaneous start and pause presses: the two channels are fully independent. Both may assert in the same cycle; arbitration belongs to the downstream FSM.
- Prescaler: 16-bit pcnt.
  - tick_en=1 and pcnt==PRESCALE-1: pcnt<=0, pulse<=1.
  - tick_en=1 otherwise: pcnt++, pulse<=0.
  - tick_en=0: pcnt<=0, pulse<=0, so the period restarts cleanly on re-enable.
  - First pulse occurs PRESCALE edges after tick_en is first sampled high.
  - PRESCALE=1 gives pulse=1 every cycle while enabled.
- No combinational path from any input to any output.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with all buttons=1 and tick_en=1. Required: start=pause=pulse=0 throughout. After release with start_btn held, exactly one start strobe at DEBOUNCE_CYCLES+2 edges.
2. Clean press, DEBOUNCE_CYCLES=4: start_btn 0->1 held 20 cycles. Required: start=1 for exactly the one cycle after edge E0+6; no strobe on release.
3. Bounce: pause_btn toggles 1,0,1,1,0 (runs shorter than 4) then holds 1. Required: pause stays 0 during bounce. pause rises 6 edges after the final stable 1 is sampled into s1, and falls 6 edges after a stable release.
4. Prescaler, PRESCALE=5: tick_en=1 for 20 cycles. Required: pulse high on cycles 5, 10, 15, 20 only. Deassert tick_en at cycle 12 and reassert at 14: next pulse at cycle 18.
5. Simultaneous: start_btn and pause_btn rise on the same edge. Required: start strobe and pause rise in the same cycle.
6. Reset mid-debounce: assert rst=0 when cnt=3 of 4. Required: no strobe. After release, the full DEBOUNCE_CYCLES+2 latency is observed again.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes and debounces the start/pause buttons and generates the prescaled count pulse
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PRESCALE        = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic start_btn,
    input  logic pause_btn,
    input  logic tick_en,
    output logic start,
    output logic pause,
    output logic pulse
);
    typedef enum logic [1:0] {S_LOW, W_HIGH, S_HIGH, W_LOW} db_state_t;

    localparam logic [7:0]  DB_MAX = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] P_LAST = 16'(PRESCALE - 1);

    // Channel 0 is start, channel 1 is pause.
    logic [1:0] s1_q, s2_q;
    db_state_t  state_q [2];
    logic [7:0] cnt_q [2];
    logic [1:0] rise_q, level_q;
    logic [15:0] pcnt_q, pcnt_d;
    logic        pulse_q, pulse_d;

    // Two-flop synchronizers for both raw buttons
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {pause_btn, start_btn};
            s2_q <= s1_q;
        end
    end

    // Per-channel debounce FSM; rise_q strobes on acceptance of a press, level_q tracks the accepted level
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= S_LOW;
                cnt_q[i]   <= '0;
            end
            rise_q  <= '0;
            level_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rise_q[i] <= 1'b0;
                case (state_q[i])
                    S_LOW: begin
                        if (s2_q[i]) begin
                            state_q[i] <= W_HIGH;
                            cnt_q[i]   <= 8'd1;
                        end
                    end
                    W_HIGH: begin
                        if (!s2_q[i]) begin
                            state_q[i] <= S_LOW;
                        end else if (cnt_q[i] == DB_MAX) begin
                            state_q[i] <= S_HIGH;
                            rise_q[i]  <= 1'b1;
                            level_q[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 8'd1;
                        end
                    end
                    S_HIGH: begin
                        if (!s2_q[i]) begin
                            state_q[i] <= W_LOW;
                            cnt_q[i]   <= 8'd1;
                        end
                    end
                    W_LOW: begin
                        if (s2_q[i]) begin
                            state_q[i] <= S_HIGH;
                        end else if (cnt_q[i] == DB_MAX) begin
                            state_q[i] <= S_LOW;
                            level_q[i] <= 1'b0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Prescaler next state: tick and wrap at PRESCALE-1, hold at zero while disabled so re-enable restarts the period
    always_comb begin
        pcnt_d  = (tick_en && pcnt_q != P_LAST) ? pcnt_q + 16'd1 : '0;
        pulse_d = tick_en && pcnt_q == P_LAST;
    end

    // Prescaler registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign start = rise_q[0];
    assign pause = level_q[1];
    assign pulse = pulse_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: table-driven scoreboard bench for btn_conditioner (DEBOUNCE_CYCLES=4, PRESCALE=5) plus a DEBOUNCE_CYCLES=1, PRESCALE=1 instance
module tb_btn_conditioner;
    logic clk = 1'b0;
    logic rst, start_btn, pause_btn, tick_en;
    logic start, pause, pulse;
    logic start1, pause1, pulse1;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic rst, sb, pb, te;
        int   reps;
        logic es, ep, eu;
    } vec_t;

    typedef struct {
        logic es, ep, eu;
        int   row;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    exp_t cur;

    btn_conditioner #(.DEBOUNCE_CYCLES(4), .PRESCALE(5)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
        .tick_en(tick_en), .start(start), .pause(pause), .pulse(pulse)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(1), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
        .tick_en(tick_en), .start(start1), .pause(pause1), .pulse(pulse1)
    );

    always #5 clk = ~clk;

    function automatic void add(logic r, logic s, logic p, logic t, int n, logic es, logic ep, logic eu);
        tbl.push_back('{r, s, p, t, n, es, ep, eu});
    endfunction

    task automatic chk(string nm, int row, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%b want=%b t=%0t", nm, row, act, exp, $time);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic s, logic p, logic t);
        @(negedge clk);
        rst = r;
        start_btn = s;
        pause_btn = p;
        tick_en = t;
    endtask

    // Scoreboard consumer: one expected record per driven cycle, compared just after the edge
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            chk("start", cur.row, start, cur.es);
            chk("pause", cur.row, pause, cur.ep);
            chk("pulse", cur.row, pulse, cur.eu);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0, n1;
        rst = 1'b0; start_btn = 1'b0; pause_btn = 1'b0; tick_en = 1'b0;
        // reset with everything asserted, then buttons held through release
        add(0,1,1,1, 3, 0,0,0);
        add(1,1,1,0, 6, 0,0,0);
        add(1,1,1,0, 1, 1,1,0);
        add(1,1,1,0,10, 0,1,0);
        add(1,0,0,0, 6, 0,1,0);
        add(1,0,0,0, 1, 0,0,0);
        add(1,0,0,0, 4, 0,0,0);
        // short start glitch, then clean press held 20 cycles and released
        add(1,1,0,0, 3, 0,0,0);
        add(1,0,0,0, 8, 0,0,0);
        add(1,1,0,0, 6, 0,0,0);
        add(1,1,0,0, 1, 1,0,0);
        add(1,1,0,0,13, 0,0,0);
        add(1,0,0,0,12, 0,0,0);
        // pause bounce 1,0,1,1,0 then stable high, a short low glitch, then stable release
        add(1,0,1,0, 1, 0,0,0);
        add(1,0,0,0, 1, 0,0,0);
        add(1,0,1,0, 2, 0,0,0);
        add(1,0,0,0, 1, 0,0,0);
        add(1,0,1,0, 6, 0,0,0);
        add(1,0,1,0, 1, 0,1,0);
        add(1,0,1,0, 5, 0,1,0);
        add(1,0,0,0, 3, 0,1,0);
        add(1,0,1,0, 8, 0,1,0);
        add(1,0,0,0, 6, 0,1,0);
        add(1,0,0,0, 1, 0,0,0);
        add(1,0,0,0, 4, 0,0,0);
        // simultaneous presses
        add(1,1,1,0, 6, 0,0,0);
        add(1,1,1,0, 1, 1,1,0);
        add(1,1,1,0, 3, 0,1,0);
        add(1,0,0,0, 6, 0,1,0);
        add(1,0,0,0, 1, 0,0,0);
        add(1,0,0,0, 3, 0,0,0);
        // prescaler: 20 enabled cycles, pulses on 5,10,15,20
        for (int k = 0; k < 4; k++) begin
            add(1,0,0,1, 4, 0,0,0);
            add(1,0,0,1, 1, 0,0,1);
        end
        add(1,0,0,0, 2, 0,0,0);
        // prescaler: disabled at 12-13, next pulse at 18
        add(1,0,0,1, 4, 0,0,0);
        add(1,0,0,1, 1, 0,0,1);
        add(1,0,0,1, 4, 0,0,0);
        add(1,0,0,1, 1, 0,0,1);
        add(1,0,0,1, 1, 0,0,0);
        add(1,0,0,0, 2, 0,0,0);
        add(1,0,0,1, 4, 0,0,0);
        add(1,0,0,1, 1, 0,0,1);
        add(1,0,0,0, 2, 0,0,0);
        // reset mid-period restarts the full period
        add(1,0,0,1, 3, 0,0,0);
        add(0,0,0,1, 1, 0,0,0);
        add(1,0,0,1, 4, 0,0,0);
        add(1,0,0,1, 1, 0,0,1);
        add(1,0,0,0, 2, 0,0,0);
        // reset at cnt=3 of 4 aborts the press; full latency after release
        add(1,1,0,0, 5, 0,0,0);
        add(0,1,0,0, 2, 0,0,0);
        add(1,1,0,0, 6, 0,0,0);
        add(1,1,0,0, 1, 1,0,0);
        add(1,1,0,0, 3, 0,0,0);
        add(1,0,0,0, 8, 0,0,0);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                drive(tbl[i].rst, tbl[i].sb, tbl[i].pb, tbl[i].te);
                sb_q.push_back('{tbl[i].es, tbl[i].ep, tbl[i].eu, i});
            end
        end

        // measured press latency on both instances, bounded at 20 edges
        n = 0; n0 = 0; n1 = 0;
        drive(1,1,0,0);
        while (n < 20 && (n0 == 0 || n1 == 0)) begin
            @(posedge clk); #1;
            n++;
            if (start === 1'b1 && n0 == 0) n0 = n;
            if (start1 === 1'b1 && n1 == 0) n1 = n;
        end
        chk_int("latency_dc4", n0 - 1, 6);
        chk_int("latency_dc1", n1 - 1, 3);
        @(posedge clk); #1;
        chk("strobe_width", -1, start, 1'b0);

        // PRESCALE=1 pulses every enabled cycle; release of start gives no strobe
        drive(1,0,0,1);
        repeat (6) begin
            @(posedge clk); #1;
            chk("pulse_p1", -1, pulse1, 1'b1);
            chk("release_nostrobe", -1, start, 1'b0);
        end
        drive(1,0,0,0);
        @(posedge clk); #1;
        chk("pulse_p1_off", -1, pulse1, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
